// File: rtl/systolic_skew_feeder.sv
// Skewed multi-lane operand feeder: lane i of a preloaded tile is delayed by i steps.
// Define SKEW_FEEDER_VALID_EN to add per-lane q_valid outputs.
module systolic_skew_feeder #(
  parameter int LANES = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        load,
  input  logic signed [LANES-1:0][DEPTH-1:0][BITS-1:0] d,
  input  logic                                        en,
  output logic signed [LANES-1:0][BITS-1:0]            q,
  output logic                                        busy,
  output logic                                        done
`ifdef SKEW_FEEDER_VALID_EN
  ,
  output logic [LANES-1:0]                            q_valid
`endif
);

  localparam int STEPS = DEPTH + LANES - 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                               state_reg, state_next;
  logic [CW-1:0]                        cnt_reg, cnt_next;
  logic                                 done_reg, done_next;
  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] tile_reg;
  logic                                 final_step;

  // load always wins over the last enabled step, so a restart never pulses done
  assign final_step = (state_reg == RUN) && en && !load && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = RUN;
    end else if (final_step) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (load) begin
      cnt_next = '0;
    end else if (state_reg == RUN && en) begin
      if (cnt_reg == LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_reg <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      if (load) begin
        tile_reg <= d;
      end
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  // lane i shows element k when cnt == i + k; outside that window it is skew padding
  always_comb begin
    busy = (state_reg == RUN);
    done = done_reg;
    q    = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (state_reg == RUN && int'(cnt_reg) == i + k) begin
          q[i] = tile_reg[i][k];
        end
      end
    end
  end

`ifdef SKEW_FEEDER_VALID_EN
  always_comb begin
    q_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_reg == RUN && int'(cnt_reg) >= i && int'(cnt_reg) < i + DEPTH) begin
        q_valid[i] = 1'b1;
      end
    end
  end
`endif

endmodule
